// File: rtl/spi_test_pkg.sv
// Shared encodings for the SPI test-pattern generator: pattern modes, FSM states
// and default Galois LFSR feedback masks.
package spi_test_pkg;

  localparam logic [1:0] MODE_CNT   = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_STROBE    = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // Right-shifting Galois masks; unknown widths fall back to the 8-bit polynomial.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      16:      default_taps = {16'h0000, LFSR_TAPS_16};
      default: default_taps = {24'h000000, LFSR_TAPS_8};
    endcase
  endfunction

endpackage

// File: rtl/spi_pattern_gen_if.sv
// Handshake bundle between the pattern generator and its host / SPI master.
interface spi_pattern_gen_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  ENABLE;
  logic [1:0]            MODE;
  logic                  BUSY;
  logic [DATA_WIDTH-1:0] DATA;
  logic                  START;
  logic                  ERR;
  logic [15:0]           WORD_CNT;

  modport master (output ENABLE, MODE, BUSY, input DATA, START, ERR, WORD_CNT);
  modport slave  (input ENABLE, MODE, BUSY, output DATA, START, ERR, WORD_CNT);

endinterface

// File: rtl/spi_pattern_core.sv
// Pattern registers plus the combinational next-word selector; load commits the
// offered word and latches the mode it was generated for.
module spi_pattern_core
  import spi_test_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED   = DATA_WIDTH'(8'h01),
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS   = DATA_WIDTH'(default_taps(DATA_WIDTH)),
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] next_word
);

  logic [DATA_WIDTH-1:0] cnt_r;
  logic [DATA_WIDTH-1:0] walk_r;
  logic [DATA_WIDTH-1:0] lfsr_r;
  logic [1:0]            mode_r;
  logic                  first_r;
  logic                  reinit_s;

  function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  // Select the initial value on a mode change or first use, otherwise the successor.
  always_comb begin
    reinit_s  = first_r || (mode != mode_r);
    next_word = '0;
    case (mode)
      MODE_CNT:   next_word = reinit_s ? '0 : cnt_r + DATA_WIDTH'(1);
      MODE_WALK:  next_word = reinit_s ? DATA_WIDTH'(1)
                                       : {walk_r[DATA_WIDTH-2:0], walk_r[DATA_WIDTH-1]};
      MODE_LFSR:  next_word = reinit_s ? LFSR_SEED : lfsr_step(lfsr_r);
      MODE_CONST: next_word = CONST_VALUE;
      default:    next_word = '0;
    endcase
  end

  // Commit the offered word into the register of the mode that produced it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      walk_r  <= DATA_WIDTH'(1);
      lfsr_r  <= LFSR_SEED;
      mode_r  <= MODE_CNT;
      first_r <= 1'b1;
    end else if (load) begin
      mode_r  <= mode;
      first_r <= 1'b0;
      case (mode)
        MODE_CNT:  cnt_r  <= next_word;
        MODE_WALK: walk_r <= next_word;
        MODE_LFSR: lfsr_r <= next_word;
        default:   cnt_r  <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_pattern_gen.sv
// Handshaked SPI test-pattern source: offers a word with a one-cycle START, waits
// for the master's BUSY acknowledge and completion, then idles for a gap.
module spi_pattern_gen
  import spi_test_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           GAP_CYCLES  = 1,
  parameter int unsigned           ACK_TIMEOUT = 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED   = DATA_WIDTH'(8'h01),
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS   = DATA_WIDTH'(default_taps(DATA_WIDTH)),
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(8'hA5)
) (
  input  logic             CLK_1KHZ,
  input  logic             RESET_N,
  spi_pattern_gen_if.slave bus
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  logic [2:0]            state_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  start_r;
  logic                  err_r;
  logic [15:0]           word_cnt_r;
  logic [TW-1:0]         to_cnt_r;
  logic [GW-1:0]         gap_cnt_r;
  logic                  load_s;
  logic                  to_last_s;
  logic                  gap_last_s;
  logic [DATA_WIDTH-1:0] next_word_s;

  spi_pattern_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LFSR_SEED   (LFSR_SEED),
    .LFSR_TAPS   (LFSR_TAPS),
    .CONST_VALUE (CONST_VALUE)
  ) u_core (
    .clk       (CLK_1KHZ),
    .rst_n     (RESET_N),
    .load      (load_s),
    .mode      (bus.MODE),
    .next_word (next_word_s)
  );

  // Launch decision and terminal-count detection for the ack and gap counters.
  always_comb begin
    if ((state_r == ST_IDLE) && bus.ENABLE && !bus.BUSY) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    to_last_s  = ((32'(to_cnt_r) + 32'd1) >= ACK_TIMEOUT);
    gap_last_s = ((32'(gap_cnt_r) + 32'd1) >= GAP_CYCLES);
  end

  // Transfer FSM with registered outputs; a timeout skips WORD_CNT but sets ERR.
  always_ff @(posedge CLK_1KHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      data_r     <= '0;
      start_r    <= 1'b0;
      err_r      <= 1'b0;
      word_cnt_r <= 16'h0000;
      to_cnt_r   <= '0;
      gap_cnt_r  <= '0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            state_r <= ST_STROBE;
            data_r  <= next_word_s;
            start_r <= 1'b1;
          end
        end
        ST_STROBE: begin
          state_r  <= ST_WAIT_ACK;
          to_cnt_r <= '0;
        end
        ST_WAIT_ACK: begin
          if (bus.BUSY) begin
            state_r <= ST_WAIT_DONE;
          end else if (to_last_s) begin
            err_r     <= 1'b1;
            state_r   <= ST_GAP;
            gap_cnt_r <= '0;
          end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.BUSY) begin
            state_r    <= ST_GAP;
            gap_cnt_r  <= '0;
            word_cnt_r <= word_cnt_r + 16'd1;
          end
        end
        ST_GAP: begin
          if (gap_last_s) begin
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.DATA     = data_r;
  assign bus.START    = start_r;
  assign bus.ERR      = err_r;
  assign bus.WORD_CNT = word_cnt_r;

endmodule
